// File: rtl/vga_pkg.sv
// vga_pkg: shared colour type and default 640x480@60 timing constants
// used by the VGA timing generator and the object-presence blocks.
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_H_TOTAL     = DEF_ACTIVE_COLS + DEF_H_FP
                                   + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_ACTIVE_ROWS = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_V_TOTAL     = DEF_ACTIVE_ROWS + DEF_V_FP
                                   + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_H_SYNC_START = DEF_ACTIVE_COLS + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_ACTIVE_ROWS + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        c.r = {4{idx[2]}};
        c.g = {4{idx[1]}};
        c.b = {4{idx[0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_pix_en.sv
// vga_pix_en: clock-enable divider, one pix_en pulse every PIX_DIV clocks.
// PIX_DIV=1 degenerates to a constant enable.
module vga_pix_en #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);

    generate
        if (PIX_DIV <= 1) begin : g_bypass
            logic unused_in;
            assign unused_in = clk ^ rst_n;
            assign pix_en    = 1'b1;
        end else begin : g_div
            localparam int DW = $clog2(PIX_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

            logic [DW-1:0] div;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    div <= '0;
                end else if (div == DIV_LAST) begin
                    div <= '0;
                end else begin
                    div <= div + 1'b1;
                end
            end

            assign pix_en = (div == DIV_LAST);
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA scan counters, sync generation and pixel compositor.
// Define VGA_TEST_PATTERN_EN to replace the background with colour bars.
module vga_timing
    import vga_pkg::*;
#(
    parameter int          PIX_DIV     = 2,
    parameter int          ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int          H_FP        = DEF_H_FP,
    parameter int          H_SYNC      = DEF_H_SYNC,
    parameter int          H_BP        = DEF_H_BP,
    parameter int          ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int          V_FP        = DEF_V_FP,
    parameter int          V_SYNC      = DEF_V_SYNC,
    parameter int          V_BP        = DEF_V_BP,
    parameter logic [11:0] FG_COLOR    = 12'hFFF,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic [$clog2(ACTIVE_ROWS)-1:0] row,
    output logic [$clog2(ACTIVE_COLS)-1:0] col,
    output logic                           active,
    input  logic                           fg_present,
    output logic                           hsync,
    output logic                           vsync,
    output logic [11:0]                    rgb,
    output logic                           vblank_start
);

    localparam int H_TOTAL = ACTIVE_COLS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = ACTIVE_ROWS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int RW      = $clog2(ACTIVE_ROWS);
    localparam int CW      = $clog2(ACTIVE_COLS);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(ACTIVE_COLS);
    localparam logic [HW-1:0] HS_BEG  = HW'(ACTIVE_COLS + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(ACTIVE_COLS + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(ACTIVE_ROWS);
    localparam logic [VW-1:0] V_VB    = VW'(ACTIVE_ROWS - 1);
    localparam logic [VW-1:0] VS_BEG  = VW'(ACTIVE_ROWS + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(ACTIVE_ROWS + V_FP + V_SYNC - 1);

    logic          pix_en;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    rgb_t          bg;
    rgb_t          pix;
    rgb_t          rgb_q;

    vga_pix_en #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_en (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en)
    );

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    // Blanking counts are masked so truncation cannot alias into object hits
    assign col    = active ? CW'(h_cnt) : '0;
    assign row    = active ? RW'(v_cnt) : '0;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    assign bar_idx = 3'(col >> 7);
    assign bg      = bar_color(bar_idx);
`else
    assign bg      = BG_COLOR;
`endif

    always_comb begin
        pix = '0;
        if (active) begin
            if (fg_present) begin
                pix = FG_COLOR;
            end else begin
                pix = bg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            rgb_q        <= '0;
            vblank_start <= 1'b0;
        end else begin
            vblank_start <= pix_en && h_wrap && (v_cnt == V_VB);
            if (pix_en) begin
                hsync <= !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
                vsync <= !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
                rgb_q <= pix;
            end
        end
    end

    assign rgb = rgb_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: random-map and directed compositing frames on a shrunken
// raster, checked every clock against an arithmetic pixel-index model.
module tb_vga_timing;

    localparam int PD  = 2;
    localparam int AC  = 40;
    localparam int HFP = 4;
    localparam int HSY = 8;
    localparam int HBP = 6;
    localparam int AR  = 20;
    localparam int VFP = 3;
    localparam int VSY = 2;
    localparam int VBP = 4;
    localparam int HT  = AC + HFP + HSY + HBP;
    localparam int VT  = AR + VFP + VSY + VBP;
    localparam int FT  = HT * VT;
    localparam int FRAME_CLK = FT * PD;
    localparam int HS0 = AC + HFP;
    localparam int HS1 = HS0 + HSY - 1;
    localparam int VS0 = AR + VFP;
    localparam int VS1 = VS0 + VSY - 1;
    localparam logic [11:0] FG = 12'hA5C;
    localparam logic [11:0] BG = 12'h3C6;
    localparam logic [31:0] RST_VEC = {8'd0, 8'd0, 1'b1, 1'b1, 1'b1,
                                       12'd0, 1'b0};

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   fg_present;
    logic                   active;
    logic                   hsync;
    logic                   vsync;
    logic                   vblank_start;
    logic [$clog2(AR)-1:0]  row;
    logic [$clog2(AC)-1:0]  col;
    logic [11:0]            rgb;

    int mode = 0;
    int tr = 0;
    int tc = 0;
    bit fg_map [1024];
    int n = 0;
    int checks = 0;
    int passes = 0;
    int hs_low, vs_low, vb_cnt, fg_cnt, fall_n, base_n;
    logic prev_hs;

    always #5 clk = ~clk;

    vga_timing #(
        .PIX_DIV     (PD),
        .ACTIVE_COLS (AC),
        .H_FP        (HFP),
        .H_SYNC      (HSY),
        .H_BP        (HBP),
        .ACTIVE_ROWS (AR),
        .V_FP        (VFP),
        .V_SYNC      (VSY),
        .V_BP        (VBP),
        .FG_COLOR    (FG),
        .BG_COLOR    (BG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .row          (row),
        .col          (col),
        .active       (active),
        .fg_present   (fg_present),
        .hsync        (hsync),
        .vsync        (vsync),
        .rgb          (rgb),
        .vblank_start (vblank_start)
    );

    // Object-presence stand-in: a combinational function of row/col
    always_comb begin
        fg_present = 1'b0;
        case (mode)
            0: fg_present = fg_map[(int'(row) * AC + int'(col)) % 1024];
            1: fg_present = (int'(row) == tr) && (int'(col) == tc);
            2: fg_present = 1'b1;
            default: fg_present = (int'(row) == 12);
        endcase
    end

    function automatic bit fg_fn(input int r, input int c);
        case (mode)
            0: return fg_map[(r * AC + c) % 1024];
            1: return (r == tr) && (c == tc);
            2: return 1'b1;
            default: return (r == 12);
        endcase
    endfunction

    function automatic logic [11:0] bg_fn(input int c);
`ifdef VGA_TEST_PATTERN_EN
        int i = (c >> 7) & 7;
        return {{4{i[2]}}, {4{i[1]}}, {4{i[0]}}};
`else
        return BG;
`endif
    endfunction

    // Expected outputs after k clock edges since reset release
    function automatic logic [31:0] exp_vec(input int k);
        int p   = k / PD;
        int cur = p % FT;
        int h   = cur % HT;
        int v   = cur / HT;
        bit act = (h < AC) && (v < AR);
        int r   = act ? v : 0;
        int c   = act ? h : 0;
        logic hs = 1'b1;
        logic vs = 1'b1;
        logic vb;
        logic [11:0] px = 12'd0;
        if (p > 0) begin
            int q  = (p - 1) % FT;
            int ph = q % HT;
            int pv = q / HT;
            hs = !((ph >= HS0) && (ph <= HS1));
            vs = !((pv >= VS0) && (pv <= VS1));
            if ((ph < AC) && (pv < AR)) px = fg_fn(pv, ph) ? FG : bg_fn(ph);
        end
        vb = ((k % PD) == 0) && (p > 0) && (cur == AR * HT);
        return {8'(r), 8'(c), act, hs, vs, px, vb};
    endfunction

    function automatic logic [31:0] got_vec();
        return {8'(row), 8'(col), active, hsync, vsync, rgb, vblank_start};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic run_cycles(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            check("cycle", got_vec(), exp_vec(n));
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (vblank_start) vb_cnt++;
            if (rgb == FG) fg_cnt++;
            if (prev_hs && !hsync && fall_n < 0) fall_n = n - base_n;
            prev_hs = hsync;
        end
    endtask

    task automatic run_frame(input int exp_fg);
        hs_low  = 0;
        vs_low  = 0;
        vb_cnt  = 0;
        fg_cnt  = 0;
        fall_n  = -1;
        base_n  = n;
        prev_hs = 1'b1;
        run_cycles(FRAME_CLK);
        check("hs_low", hs_low, VT * HSY * PD);
        check("vs_low", vs_low, VSY * HT * PD);
        check("vblank", vb_cnt, 1);
        check("fg_px", fg_cnt, exp_fg * PD);
        check("h_fall", fall_n, (HS0 + 1) * PD);
    endtask

    function automatic int map_hits();
        int s = 0;
        for (int r = 0; r < AR; r++)
            for (int c = 0; c < AC; c++)
                s += int'(fg_map[(r * AC + c) % 1024]);
        return s;
    endfunction

    task automatic new_map();
        for (int i = 0; i < 1024; i++) fg_map[i] = ($urandom_range(7) == 0);
    endtask

    initial begin
        new_map();
        mode  = 0;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst", got_vec(), RST_VEC);
        end
        rst_n = 1'b1;
        n     = 0;

        run_frame(map_hits());

        mode = 1;
        tr   = $urandom_range(AR - 1);
        tc   = $urandom_range(AC - 1);
        run_frame(1);

        mode = 2;
        run_frame(AR * AC);

        mode = 3;
        run_frame(AC);

        mode = 0;
        new_map();
        run_cycles(((AR / 2) * HT + int'($urandom_range(AC - 1))) * PD + 1);
        #2 rst_n = 1'b0;
        #1 check("arst", got_vec(), RST_VEC);
        repeat (3) begin
            @(negedge clk);
            check("arst_hold", got_vec(), RST_VEC);
        end
        rst_n = 1'b1;
        n     = 0;

        run_frame(map_hits());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
